// File: rtl/vending_fsm_param_if.sv
// Coin/button inputs and dispenser/hopper outputs of the parametrised vending FSM.
// The controller side uses the slave modport and the stimulus side uses the master modport.
interface vending_fsm_param_if #(
    parameter int CNT_W = 4
);
    logic             pi_half;
    logic             pi_one;
    logic             pi_cancel;
    logic             po_cola;
    logic             po_half;
    logic             po_busy;
    logic             po_coin_rej;
    logic [CNT_W-1:0] po_credit;

    modport master (
        output pi_half, pi_one, pi_cancel,
        input  po_cola, po_half, po_busy, po_coin_rej, po_credit
    );

    modport slave (
        input  pi_half, pi_one, pi_cancel,
        output po_cola, po_half, po_busy, po_coin_rej, po_credit
    );
endinterface

// File: rtl/vending_fsm_param.sv
// Single-product coin vending controller with a configurable price, change and refund payout.
// Credit and payout counts are held in half-units, and every output is taken directly from a flop.
module vending_fsm_param #(
    parameter int PRICE = 5,
    parameter int CNT_W = 4
) (
    input logic                sys_clk,
    input logic                sys_rst,
    vending_fsm_param_if.slave bus
);
    typedef enum logic [2:0] {
        COLLECT = 3'b001,
        CHANGE  = 3'b010,
        REFUND  = 3'b100
    } state_e;

    localparam int             W       = CNT_W + 1;
    localparam logic [W-1:0]   PRICE_W = W'(PRICE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cola_q, cola_d;
    logic             half_q, half_d;
    logic             busy_q, busy_d;
    logic             rej_q, rej_d;

    logic             coin_bad;
    logic [W-1:0]     coin_val;
    logic [W-1:0]     sum_w;
    logic [W-1:0]     excess_w;
    logic             in_collect;
    logic             in_payout;
    logic             vend;
    logic             refund;

    // One extra bit of headroom: credit + coin tops out at PRICE+1.
    always_comb begin
        coin_bad   = bus.pi_half & bus.pi_one;
        coin_val   = coin_bad ? '0 : {{(W-2){1'b0}}, bus.pi_one, bus.pi_half};
        sum_w      = {1'b0, credit_q} + coin_val;
        excess_w   = sum_w - PRICE_W;
        in_collect = (state_q == COLLECT);
        in_payout  = (state_q == CHANGE) || (state_q == REFUND);
        refund     = in_collect && bus.pi_cancel && (sum_w != '0);
        vend       = in_collect && !bus.pi_cancel && (sum_w >= PRICE_W);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: the reset is synchronous and clears every flop, because discarding pending change is part of its function.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            cnt_q    <= '0;
            cola_q   <= 1'b0;
            half_q   <= 1'b0;
            busy_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            cola_q   <= cola_d;
            half_q   <= half_d;
            busy_q   <= busy_d;
            rej_q    <= rej_d;
        end
    end

    // cnt_q holds the number of payout pulses still owed after the current one.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        case (state_q)
            COLLECT: begin
                if (bus.pi_cancel) begin
                    if (refund) begin
                        state_d  = REFUND;
                        credit_d = '0;
                        cnt_d    = CNT_W'(sum_w - W'(1));
                    end
                end else if (vend) begin
                    credit_d = '0;
                    if (excess_w > W'(1)) begin
                        state_d = CHANGE;
                        cnt_d   = CNT_W'(excess_w - W'(1));
                    end
                end else begin
                    credit_d = CNT_W'(sum_w);
                end
            end
            CHANGE, REFUND: begin
                if (cnt_q == '0) begin
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_comb begin
        cola_d = vend;
        half_d = refund || (vend && (excess_w != '0)) || (in_payout && (cnt_q != '0));
        busy_d = (state_d == CHANGE) || (state_d == REFUND);
        rej_d  = coin_bad || (in_payout && (bus.pi_half || bus.pi_one));
    end

    assign bus.po_cola     = cola_q;
    assign bus.po_half     = half_q;
    assign bus.po_busy     = busy_q;
    assign bus.po_coin_rej = rej_q;
    assign bus.po_credit   = credit_q;
endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for three price/width variants driven by one shared stimulus stream.
// An integer-level payout model is compared every cycle, and directed literal checks pin the model.
module tb_vending_fsm_param;
    logic sys_clk = 1'b0;
    logic rst = 1'b0;
    logic half_in = 1'b0;
    logic one_in = 1'b0;
    logic cancel_in = 1'b0;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    always #5 sys_clk = ~sys_clk;

    vending_fsm_param_if #(.CNT_W(4)) if5 ();
    vending_fsm_param_if #(.CNT_W(2)) if1 ();
    vending_fsm_param_if #(.CNT_W(3)) if3 ();

    vending_fsm_param #(.PRICE(5), .CNT_W(4)) dut5 (.sys_clk(sys_clk), .sys_rst(rst), .bus(if5));
    vending_fsm_param #(.PRICE(1), .CNT_W(2)) dut1 (.sys_clk(sys_clk), .sys_rst(rst), .bus(if1));
    vending_fsm_param #(.PRICE(3), .CNT_W(3)) dut3 (.sys_clk(sys_clk), .sys_rst(rst), .bus(if3));

    assign if5.pi_half = half_in;  assign if5.pi_one = one_in;  assign if5.pi_cancel = cancel_in;
    assign if1.pi_half = half_in;  assign if1.pi_one = one_in;  assign if1.pi_cancel = cancel_in;
    assign if3.pi_half = half_in;  assign if3.pi_one = one_in;  assign if3.pi_cancel = cancel_in;

    // Model per variant: credit, pulses still owed, and expected outputs after each edge.
    int price_m [3] = '{5, 1, 3};
    int credit_m [3];
    int owed_m [3];
    bit cola_m [3];
    bit half_m [3];
    bit busy_m [3];
    bit rej_m [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic c, input logic h, input logic b,
                                         input logic r, input logic [7:0] cr);
        return {20'd0, c, h, b, r, cr};
    endfunction

    task automatic model_step(input int k);
        int  c;
        int  s;
        int  e;
        bit  bad;
        bad = half_in && one_in;
        c = bad ? 0 : (one_in ? 2 : (half_in ? 1 : 0));
        cola_m[k] = 1'b0;
        half_m[k] = 1'b0;
        rej_m[k]  = 1'b0;
        if (rst) begin
            credit_m[k] = 0;
            owed_m[k]   = 0;
            busy_m[k]   = 1'b0;
        end else if (busy_m[k]) begin
            rej_m[k] = half_in || one_in;
            if (owed_m[k] > 0) begin
                half_m[k] = 1'b1;
                owed_m[k] = owed_m[k] - 1;
            end else begin
                busy_m[k] = 1'b0;
            end
        end else begin
            rej_m[k] = bad;
            s = credit_m[k] + c;
            if (cancel_in) begin
                if (s > 0) begin
                    half_m[k]   = 1'b1;
                    busy_m[k]   = 1'b1;
                    owed_m[k]   = s - 1;
                    credit_m[k] = 0;
                end
            end else if (s >= price_m[k]) begin
                cola_m[k]   = 1'b1;
                credit_m[k] = 0;
                e = s - price_m[k];
                half_m[k] = (e > 0);
                if (e > 1) begin
                    busy_m[k] = 1'b1;
                    owed_m[k] = e - 1;
                end
            end else begin
                credit_m[k] = s;
            end
        end
    endtask

    always @(posedge sys_clk) begin
        if (rst) started = 1'b1;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge sys_clk) begin
        if (started) begin
            check("p5_outputs", pack(if5.po_cola, if5.po_half, if5.po_busy, if5.po_coin_rej, 8'(if5.po_credit)),
                  pack(cola_m[0], half_m[0], busy_m[0], rej_m[0], 8'(credit_m[0])));
            check("p1_outputs", pack(if1.po_cola, if1.po_half, if1.po_busy, if1.po_coin_rej, 8'(if1.po_credit)),
                  pack(cola_m[1], half_m[1], busy_m[1], rej_m[1], 8'(credit_m[1])));
            check("p3_outputs", pack(if3.po_cola, if3.po_half, if3.po_busy, if3.po_coin_rej, 8'(if3.po_credit)),
                  pack(cola_m[2], half_m[2], busy_m[2], rej_m[2], 8'(credit_m[2])));
        end
    end

    task automatic step(input bit h, input bit o, input bit c);
        @(negedge sys_clk);
        rst = 1'b0;
        half_in = h;
        one_in = o;
        cancel_in = c;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        half_in = 1'b0;
        one_in = 1'b0;
        cancel_in = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int p3_pulses;
        bit cola_seen;

        // Reset state
        do_reset();
        check("reset_p5_all", pack(if5.po_cola, if5.po_half, if5.po_busy, if5.po_coin_rej, 8'(if5.po_credit)), 0);

        // Five half coins reach PRICE=5 exactly
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0);
            check("halves_credit", 32'(if5.po_credit), i);
        end
        step(1, 0, 0);
        check("halves_cola", 32'(if5.po_cola), 1);
        check("halves_no_change", 32'(if5.po_half), 0);
        check("halves_credit0", 32'(if5.po_credit), 0);
        step(0, 0, 0);
        check("halves_cola_one_cycle", 32'(if5.po_cola), 0);

        // Three one-unit coins: vend plus one change pulse; also exercises PRICE=1 and PRICE=3
        do_reset();
        step(0, 1, 0);
        check("ones_credit2", 32'(if5.po_credit), 2);
        check("p1_cola", 32'(if1.po_cola), 1);
        check("p1_half", 32'(if1.po_half), 1);
        check("p1_busy", 32'(if1.po_busy), 0);
        check("p3_credit2", 32'(if3.po_credit), 2);
        step(0, 1, 0);
        check("ones_credit4", 32'(if5.po_credit), 4);
        check("p3_cola", 32'(if3.po_cola), 1);
        p3_pulses = int'(if3.po_half);
        step(0, 1, 0);
        p3_pulses += int'(if3.po_half);
        check("ones_cola_half", {30'd0, if5.po_cola, if5.po_half}, 32'b11);
        check("ones_busy0", 32'(if5.po_busy), 0);
        check("ones_credit0", 32'(if5.po_credit), 0);
        step(0, 0, 0);
        p3_pulses += int'(if3.po_half);
        check("p3_single_change", p3_pulses, 1);
        check("ones_half_done", 32'(if5.po_half), 0);

        // Refund of 3 with a coin rejected mid-refund
        do_reset();
        step(1, 0, 0);
        step(0, 1, 0);
        check("refund_credit3", 32'(if5.po_credit), 3);
        step(0, 0, 1);
        check("refund_c1", {30'd0, if5.po_half, if5.po_busy}, 32'b11);
        step(0, 0, 0);
        check("refund_c2", {30'd0, if5.po_half, if5.po_busy}, 32'b11);
        step(1, 0, 0);
        check("refund_c3", {29'd0, if5.po_half, if5.po_busy, if5.po_coin_rej}, 32'b111);
        check("refund_no_credit", 32'(if5.po_credit), 0);
        step(0, 0, 0);
        check("refund_done", {29'd0, if5.po_half, if5.po_busy, if5.po_coin_rej}, 0);
        check("refund_credit_after", 32'(if5.po_credit), 0);

        // Illegal coin, then cancel together with a coin at credit 4
        do_reset();
        step(0, 1, 0);
        step(1, 1, 0);
        check("illegal_rej", 32'(if5.po_coin_rej), 1);
        check("illegal_credit", 32'(if5.po_credit), 2);
        step(0, 1, 0);
        check("illegal_credit4", 32'(if5.po_credit), 4);
        step(0, 1, 1);
        pulses = 0;
        cola_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (if5.po_half) pulses++;
            if (if5.po_cola) cola_seen = 1'b1;
            step(0, 0, 0);
        end
        check("cancel_coin_pulses", pulses, 6);
        check("cancel_no_cola", 32'(cola_seen), 0);

        // Reset in the middle of a refund
        do_reset();
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        check("midrst_refund_on", 32'(if5.po_half), 1);
        do_reset();
        check("midrst_all0", pack(if5.po_cola, if5.po_half, if5.po_busy, if5.po_coin_rej, 8'(if5.po_credit)), 0);
        step(0, 1, 0);
        check("midrst_credit2", 32'(if5.po_credit), 2);
        check("midrst_no_half", 32'(if5.po_half), 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            end
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
